// File: rtl/apb4_ram_param.sv
// rtl/apb4_ram_param.sv - parametrised APB4 slave RAM with byte strobes, wait states and pslverr
module apb4_ram_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 48,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state, next_state;
  logic [3:0]            cnt;
  logic [IDX_W-1:0]      cap_idx;
  logic                  cap_write, cap_err;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [STRB_W-1:0]     cap_strb;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [IDX_W-1:0]      live_idx, sel_idx;
  logic                  live_err, sel_err, sel_write;
  logic [DATA_WIDTH-1:0] comp_rdata;
  logic                  setup, done, abort, comp_load, cnt_dec;

  assign live_idx = paddr[ADDR_WIDTH-1:OFF_W];
  assign live_err = 32'(live_idx) >= 32'(DEPTH);

  generate
    if (OFF_W > 0) begin : g_off
      logic unused_off;
      assign unused_off = ^paddr[OFF_W-1:0];
    end
  endgenerate

  // With zero wait states the completion is loaded on the setup edge, so it
  // must be computed from the live bus rather than the capture registers.
  assign sel_idx    = (state == IDLE) ? live_idx : cap_idx;
  assign sel_err    = (state == IDLE) ? live_err : cap_err;
  assign sel_write  = (state == IDLE) ? pwrite   : cap_write;
  assign comp_rdata = (sel_write || sel_err) ? '0 : mem[sel_idx[MEM_AW-1:0]];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (setup) next_state = ACCESS;
      ACCESS:  if (done || abort) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    setup     = (state == IDLE) && psel && !penable;
    done      = (state == ACCESS) && psel && penable && pready;
    abort     = (state == ACCESS) && !psel;
    cnt_dec   = (state == ACCESS) && psel && (cnt != 4'd0);
    comp_load = (setup && (WAIT_STATES == 0)) || (cnt_dec && (cnt == 4'd1));
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt       <= '0;
      cap_idx   <= '0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
    end else begin
      if (setup) begin
        cnt       <= 4'(WAIT_STATES);
        cap_idx   <= live_idx;
        cap_write <= pwrite;
        cap_err   <= live_err;
        cap_wdata <= pwdata;
        cap_strb  <= pstrb;
      end else if (cnt_dec) begin
        cnt <= cnt - 4'd1;
      end
      if (comp_load) begin
        pready  <= 1'b1;
        pslverr <= sel_err;
        prdata  <= comp_rdata;
      end else if (done || abort) begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (done && cap_write && !cap_err) begin
      for (int i = 0; i < STRB_W; i++)
        if (cap_strb[i]) mem[cap_idx[MEM_AW-1:0]][8*i +: 8] <= cap_wdata[8*i +: 8];
    end
  end
endmodule

// File: doc/apb4_ram_param.md
Name: apb4_ram_param

Overview:
- Parametrised APB4 slave RAM; successor to the fixed-size APB RAM used as our APB DUT.
- Adds configurable data width, depth and address width, byte-lane write strobes (pstrb), programmable wait states, and pslverr on out-of-range addresses.
- Sits on the APB bus behind a bridge/master; the class-based tb_top environment drives it through an extended RAM interface.

Parameters:
- DATA_WIDTH, 32, bus/word width; legal values 8, 16, 32, 64.
- DEPTH, 48, number of words; flop-based storage, DEPTH ≤ 256.
- ADDR_WIDTH, 8, byte address width; must satisfy ADDR_WIDTH ≥ clog2(DEPTH) + clog2(DATA_WIDTH/8).
- WAIT_STATES, 2, pready-low cycles inserted in the ACCESS phase; range 0..15.

Ports:
- pclk  in  1  APB clock; all state updates on rising edge.
- presetn  in  1  asynchronous, active-low reset.
- psel  in  1  slave select.
- penable  in  1  access phase strobe.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  byte-lane write enables.
- prdata  out  DATA_WIDTH  read data; registered.
- pready  out  1  transfer completion; registered.
- pslverr  out  1  error response, valid only while pready=1; registered.

Behaviour:
- Reset (presetn=0, asynchronous):
  - FSM goes to IDLE.
  - pready=0, pslverr=0, prdata=0, wait counter=0.
  - All memory words are cleared to 0.
- Word index = paddr[ADDR_WIDTH-1 : clog2(DATA_WIDTH/8)]; the low byte-offset bits are ignored.
- Error condition: err = (word index ≥ DEPTH).
- FSM states: IDLE, ACCESS.
- IDLE:
  - On an edge with psel=1 and penable=0 (setup phase), capture paddr, pwrite, pwdata, pstrb and err.
  - Load the wait counter with WAIT_STATES and move to ACCESS.
- ACCESS:
  - Each edge with counter > 0 decrements the counter; pready stays 0.
  - pready=1 in the cycle after the counter reaches 0.
  - Total ACCESS-phase length is WAIT_STATES+1 cycles.
  - Example: with WAIT_STATES=0, pready=1 in the first penable cycle.
- Completion data, registered together with pready:
  - Read, no err: prdata = mem[index].
  - err: prdata = 0 and pslverr=1.
  - Write: prdata = 0.
- Write commit:
  - Occurs on the completing edge (pready=1, psel=1, penable=1) with err=0.
  - Only lanes with pstrb[i]=1 are updated.
  - pstrb all-zero: no change, no error.
  - On reads, pstrb is ignored.
- After the completing edge:
  - pready and pslverr return to 0 and the FSM returns to IDLE.
  - prdata holds its value until the next completion.
- Back-to-back: a setup phase in the cycle immediately after completion is accepted normally; the FSM passes through IDLE for that one cycle.
- Address, control and data are taken from the setup-phase capture; changes on the bus during ACCESS are ignored.
- Protocol violations:
  - psel dropping during ACCESS: abort to IDLE, no write, pready/pslverr=0.
  - penable=1 while in IDLE: ignored.
- Reset asserted mid-transfer: the transfer is abandoned, no write is committed, and all state goes to reset values.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then idle: presetn low 3 cycles → pready=0, pslverr=0, prdata=0; a read of 0x00 returns 0x00000000.
- Write/read with WAIT_STATES=2: write 0xDEADBEEF to 0x10 with pstrb=0xF → pready low for 2 ACCESS cycles, high on the 3rd; reading 0x10 returns 0xDEADBEEF with pslverr=0.
- Byte strobes: write 0x11223344 to 0x20 with pstrb=0xF, then 0xAABBCCDD with pstrb=0x5 → reading 0x20 returns 0x11BB33DD.
- Out-of-range: write 0x12345678 to 0xC0 (index 48) → pslverr=1 with pready and no memory change; reading 0xC0 returns prdata=0, pslverr=1; reading 0xBC returns its stored value with pslverr=0.
- Back-to-back with WAIT_STATES=0: write 0x1 to 0x04, then immediately read 0x04 → each transfer completes in 1 ACCESS cycle; the read returns 0x00000001.
- Abort and reset: drop psel mid-ACCESS on a write to 0x08 → 0x08 unchanged. Assert presetn mid-write to 0x0C → outputs return to 0 immediately and 0x0C reads 0.
